// File: rtl/cmd_sched.sv
// Command scheduler: buffers UART route commands in a FIFO and releases them one at a time
// with a dead gap between commands. Optional pop counter port enabled by CMD_SCHED_STATS_EN.
module cmd_sched #(
   parameter int DEPTH   = 4,
   parameter int GAP_CYC = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [15:0]                uart_cmd,
   input  logic                       uart_cmd_rdy,
   output logic                       uart_clr_cmd_rdy,
   output logic [15:0]                cmd,
   output logic                       cmd_rdy,
   input  logic                       clr_cmd_rdy,
   output logic                       abort,
   output logic [$clog2(DEPTH):0]     q_cnt,
   output logic                       ovfl,
`ifdef CMD_SCHED_STATS_EN
   output logic [7:0]                 pop_cnt,
`endif
   output logic [1:0]                 dbg_state
);

   localparam int PW       = $clog2(DEPTH);
   localparam int CW       = PW + 1;
   localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PRESENT = 2'd1;
   localparam logic [1:0] GAP     = 2'd2;

   logic [15:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] q_next;
   logic [GW-1:0] gap_cnt;
   logic [1:0]    state;
   logic          full, is_abort, push, pop;

   // Both handshakes are valid/ready style: the UART holds uart_cmd_rdy with a stable word
   // until uart_clr_cmd_rdy is seen, and the consumer pops only while cmd_rdy is high.
   assign full             = (q_cnt == CW'(DEPTH));
   assign is_abort         = uart_cmd_rdy && (uart_cmd == 16'h0000);
   assign push             = uart_cmd_rdy && (uart_cmd != 16'h0000) && !full;
   assign pop              = (state == PRESENT) && clr_cmd_rdy;
   assign uart_clr_cmd_rdy = !rst && (is_abort || push);
   assign cmd              = mem[rd_ptr];
   assign cmd_rdy          = (state == PRESENT);
   assign dbg_state        = state;

   always_comb begin
      q_next = q_cnt;
      case ({push, pop})
         2'b10:   q_next = q_cnt + CW'(1);
         2'b01:   q_next = q_cnt - CW'(1);
         default: q_next = q_cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= uart_cmd;
   end

   always_ff @(posedge clk) begin
      if (rst || is_abort) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_cnt   <= '0;
         gap_cnt <= '0;
         ovfl    <= 1'b0;
         abort   <= !rst;
`ifdef CMD_SCHED_STATS_EN
         pop_cnt <= 8'd0;
`endif
      end else begin
         abort <= 1'b0;
         q_cnt <= q_next;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (uart_cmd_rdy && full) ovfl <= 1'b1;
`ifdef CMD_SCHED_STATS_EN
         if (pop) pop_cnt <= pop_cnt + 8'd1;
`endif
         case (state)
            IDLE: begin
               if (q_next != '0) state <= PRESENT;
            end
            PRESENT: begin
               if (pop) begin
                  if (GAP_CYC > 0) begin
                     state   <= GAP;
                     gap_cnt <= GW'(GAP_LOAD);
                  end else if (q_next == '0) begin
                     state <= IDLE;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) state <= (q_next != '0) ? PRESENT : IDLE;
               else               gap_cnt <= gap_cnt - GW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
